usb4_lane_link_ctrl: RTL and testbench
======================================

Name: usb4_lane_link_ctrl

Overview:
- Simplified USB4 logical-layer core for one router port with two lanes.
- Raises the sideband and trains both lanes with a training byte, then enters CL0.
- In CL0 it stripes and scrambles 16-bit transport data across two byte lanes, and receives, descrambles and merges the reverse path.
- Exposes a small config-space register file.
- Sits between the transport layer and the electrical layer.

Parameters:
- TS_BYTE, 8'h4A: training symbol sent and expected on both lanes.
- TS_COUNT, 16: consecutive TS_BYTE words required on both rx lanes.
- SB_DEBOUNCE, 8: cycles sbrx must stay high before training.
- SCR_SEED, 23'h1DBFBC: LFSR seed for every scrambler/descrambler.
- DEV_ID, 32'h5553_4234: read-only ID register value.

Ports:
- local_clk  in  1  sole clock
- rst  in  1  reset, synchronous, active-high
- lane_disable  in  1  forces DISABLED
- c_read  in  1  config read strobe
- c_write  in  1  config write strobe
- c_address  in  8  config byte address
- c_data_in  in  32  config write data
- c_data_out  out  32  config read data
- transport_layer_data_in  in  16  tx data; [7:0] to lane0, [15:8] to lane1
- transport_layer_data_out  out  16  rx data
- transport_data_flag  out  1  transport_layer_data_out valid
- lane_0_rx_i / lane_1_rx_i  in  8  rx bytes
- enable_deser  in  1  rx bytes valid this cycle
- sbrx  in  1  sideband receive level
- sbtx  out  1  sideband transmit level
- lane_0_tx_o / lane_1_tx_o  out  8  tx bytes
- enable_scr  out  1  scrambling active
- cl0_s  out  1  link in CL0

Behaviour:
- One clock domain: local_clk, reset rst, synchronous, active-high.
- Reset values: all outputs 0; state DISABLED; control register 0; counters 0; all LFSRs = SCR_SEED.
- FSM states and transitions:
  - DISABLED: sbtx=0, tx lanes 0. Leaves to CLD in the next cycle when lane_disable=0 and ctrl.sw_disable=0.
  - CLD: sbtx=1. Counts cycles with sbrx=1; any sbrx=0 clears the count. Count reaching SB_DEBOUNCE moves to TRAINING.
  - TRAINING: sbtx=1; both tx lanes = TS_BYTE every cycle.
    - Per-lane counter increments on enable_deser cycles where that lane's rx equals TS_BYTE. A mismatch on a valid cycle clears that lane's counter. Counters saturate at TS_COUNT.
    - Both counters at TS_COUNT moves to CL0. All four LFSRs reload SCR_SEED on this transition.
  - CL0: cl0_s=1, enable_scr=1, sbtx=1.
- Priority, highest first (evaluated every cycle):
  1. lane_disable=1 or ctrl.sw_disable=1 -> DISABLED.
  2. sbrx=0 in TRAINING or CL0 -> CLD.
  3. ctrl.retrain pulse in CL0 -> TRAINING, with training counters cleared.
- Scrambler:
  - Polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, Fibonacci, additive.
  - Each byte is XORed with 8 successive LFSR output bits (LSB first); the LFSR advances 8 steps per byte.
  - Tx LFSRs (one per lane) advance every CL0 cycle.
  - Rx LFSRs (one per lane) advance only on enable_deser cycles in CL0.
- Tx path: lane_x_tx_o = registered (data byte XOR keystream). Latency 1 cycle from transport_layer_data_in.
- Rx path: on enable_deser in CL0, transport_layer_data_out = {descr(lane1), descr(lane0)} and transport_data_flag=1 in the next cycle; otherwise flag=0 and data holds its last value.
- Outside CL0: enable_scr=0, cl0_s=0, transport_data_flag=0.
- Config space (word addresses; other addresses read 0, writes ignored):
  - 0x00 ID, read-only, DEV_ID.
  - 0x04 CTRL:
    - bit0 sw_disable, read/write.
    - bit1 retrain, write-1 pulse, self-clearing, reads 0.
  - 0x08 STATUS, read-only: [1:0] state (DISABLED=0, CLD=1, TRAINING=2, CL0=3), [2] cl0_s, [3] sbrx.
  - Read latency 1 cycle; c_data_out holds until the next read.
  - Simultaneous c_read and c_write to the same address: the read returns the old value.

Decomposition:
- Shared package usb4_ll_pkg holds: the state enum, register address constants, the polynomial tap mask and SCR_SEED.
- One sub-module, usb4_byte_scrambler (LFSR + 8-bit keystream XOR, load/advance inputs), instantiated four times: tx0, tx1, rx0, rx1.

Test Plan:
- Reset then lane_disable=1: sbtx=0, cl0_s=0, STATUS read = 0x0.
- lane_disable=0, sbrx high for 7 cycles then low for 1, then high 8 cycles -> TRAINING entered only after the uninterrupted 8; lane_0_tx_o = lane_1_tx_o = 8'h4A.
- Feed 16 valid TS_BYTE on both lanes, one lane corrupted at word 10 -> no CL0 until that lane completes 16 clean consecutive words; then cl0_s=1, enable_scr=1.
- Loopback tx lanes to rx lanes with enable_deser=1 in CL0, input 16'h1234, 16'hABCD -> transport_layer_data_out returns the same values after 2 cycles, transport_data_flag=1; lane tx bytes differ from plaintext.
- Write CTRL=0x2 in CL0 -> TRAINING, cl0_s drops next cycle; CTRL reads back 0x0.
- Read 0x00 -> 32'h5553_4234 one cycle after c_read; write CTRL=0x1 -> DISABLED, sbtx=0.

Source files
------------

// File: rtl/usb4_ll_pkg.sv
// Shared types and constants for the USB4 lane link controller:
// link states, config-space map and scrambler polynomial/seed.
package usb4_ll_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_CLD      = 2'd1,
        ST_TRAINING = 2'd2,
        ST_CL0      = 2'd3
    } ll_state_e;

    typedef struct packed {
        logic      sbrx;
        logic      cl0;
        ll_state_e state;
    } status_t;

    localparam logic [7:0] ADDR_ID     = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;

    localparam int          LFSR_W   = 23;
    // x^23+x^21+x^16+x^8+x^5+x^2+1 as taps on state bits 22,20,15,7,4,1
    localparam logic [22:0] SCR_TAPS = 23'h508092;
    localparam logic [22:0] SCR_SEED = 23'h1DBFBC;

    function automatic logic [22:0] lfsr_step(input logic [22:0] s);
        return {s[21:0], ^(s & SCR_TAPS)};
    endfunction

endpackage

// File: rtl/usb4_lane_link_ctrl_if.sv
// Config-space access bus between the host side and the link controller.
interface usb4_lane_link_ctrl_if;
    logic        c_read;
    logic        c_write;
    logic [7:0]  c_address;
    logic [31:0] c_data_in;
    logic [31:0] c_data_out;

    modport master (output c_read, c_write, c_address, c_data_in, input c_data_out);
    modport slave  (input c_read, c_write, c_address, c_data_in, output c_data_out);
endinterface

// File: rtl/usb4_byte_scrambler.sv
// Additive byte scrambler: 23-bit Fibonacci LFSR, 8 keystream bits per byte, LSB first.
module usb4_byte_scrambler
    import usb4_ll_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [LFSR_W-1:0] lfsr, lfsr_adv;
    logic [7:0]        ks;

    always_comb begin
        lfsr_adv = lfsr;
        ks       = '0;
        for (int b = 0; b < 8; b++) begin
            ks[b]    = lfsr_adv[LFSR_W-1];
            lfsr_adv = lfsr_step(lfsr_adv);
        end
    end

    assign dout = din ^ ks;

    always_ff @(posedge clk) begin
        if (rst || load) lfsr <= SCR_SEED;
        else if (advance) lfsr <= lfsr_adv;
    end
endmodule

// File: rtl/usb4_lane_link_ctrl.sv
// Two-lane USB4 logical-layer core: sideband bring-up, lane training, CL0
// striping with scrambling, and a small config register file.
module usb4_lane_link_ctrl
    import usb4_ll_pkg::*;
#(
    parameter logic [7:0]  TS_BYTE     = 8'h4A,
    parameter int          TS_COUNT    = 16,
    parameter int          SB_DEBOUNCE = 8,
    parameter logic [31:0] DEV_ID      = 32'h5553_4234
) (
    input  logic                 local_clk,
    input  logic                 rst,
    input  logic                 lane_disable,
    usb4_lane_link_ctrl_if.slave cfg,
    input  logic [15:0]          transport_layer_data_in,
    output logic [15:0]          transport_layer_data_out,
    output logic                 transport_data_flag,
    input  logic [7:0]           lane_0_rx_i,
    input  logic [7:0]           lane_1_rx_i,
    input  logic                 enable_deser,
    input  logic                 sbrx,
    output logic                 sbtx,
    output logic [7:0]           lane_0_tx_o,
    output logic [7:0]           lane_1_tx_o,
    output logic                 enable_scr,
    output logic                 cl0_s
);
    localparam int NUM_LANES = 2;
    localparam int TW        = $clog2(TS_COUNT + 1);
    localparam int DW        = $clog2(SB_DEBOUNCE + 1);

    ll_state_e                    state, state_nxt;
    logic                         sw_disable, retrain, in_cl0, rx_take, scr_load;
    logic [DW-1:0]                sb_cnt;
    logic [NUM_LANES-1:0][7:0]    rx_lane, tx_plain, tx_scr, rx_descr, tx_lane;
    logic [NUM_LANES-1:0]         ts_done;
    logic [31:0]                  rdata;
    status_t                      st;
    logic                         cfg_unused;

    // Retrain is a decoded write strobe, so it never holds state and reads back 0.
    assign retrain    = cfg.c_write && (cfg.c_address == ADDR_CTRL) && cfg.c_data_in[1];
    assign cfg_unused = ^cfg.c_data_in[31:2];
    assign rx_lane    = {lane_1_rx_i, lane_0_rx_i};
    assign tx_plain   = transport_layer_data_in;
    assign in_cl0     = (state == ST_CL0);
    assign rx_take    = in_cl0 && enable_deser;
    assign scr_load   = (state == ST_TRAINING) && (state_nxt == ST_CL0);
    assign lane_0_tx_o = tx_lane[0];
    assign lane_1_tx_o = tx_lane[1];

    always_comb begin
        state_nxt = state;
        if (lane_disable || sw_disable) state_nxt = ST_DISABLED;
        else begin
            case (state)
                ST_DISABLED: state_nxt = ST_CLD;
                ST_CLD:      if (sbrx && sb_cnt == DW'(SB_DEBOUNCE - 1)) state_nxt = ST_TRAINING;
                ST_TRAINING: if (!sbrx) state_nxt = ST_CLD;
                             else if (&ts_done) state_nxt = ST_CL0;
                ST_CL0:      if (!sbrx) state_nxt = ST_CLD;
                             else if (retrain) state_nxt = ST_TRAINING;
                default:     state_nxt = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            state      <= ST_DISABLED;
            sbtx       <= 1'b0;
            cl0_s      <= 1'b0;
            enable_scr <= 1'b0;
            sb_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            sbtx       <= (state_nxt != ST_DISABLED);
            cl0_s      <= (state_nxt == ST_CL0);
            enable_scr <= (state_nxt == ST_CL0);
            if (state == ST_CLD && state_nxt == ST_CLD && sbrx) sb_cnt <= sb_cnt + 1'b1;
            else sb_cnt <= '0;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [TW-1:0] cnt;
        logic [7:0]    tx_q;

        usb4_byte_scrambler u_tx (
            .clk(local_clk), .rst(rst), .load(scr_load), .advance(in_cl0),
            .din(tx_plain[i]), .dout(tx_scr[i])
        );
        usb4_byte_scrambler u_rx (
            .clk(local_clk), .rst(rst), .load(scr_load), .advance(rx_take),
            .din(rx_lane[i]), .dout(rx_descr[i])
        );

        assign ts_done[i] = (cnt == TW'(TS_COUNT));
        assign tx_lane[i] = tx_q;

        // Counters only live in TRAINING, which also clears them on a retrain.
        always_ff @(posedge local_clk) begin
            if (rst || state != ST_TRAINING) cnt <= '0;
            else if (enable_deser) begin
                if (rx_lane[i] != TS_BYTE) cnt <= '0;
                else if (!ts_done[i]) cnt <= cnt + 1'b1;
            end

            if (rst) tx_q <= '0;
            else begin
                case (state)
                    ST_TRAINING: tx_q <= TS_BYTE;
                    ST_CL0:      tx_q <= tx_scr[i];
                    default:     tx_q <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            transport_layer_data_out <= '0;
            transport_data_flag      <= 1'b0;
        end else begin
            transport_data_flag <= rx_take;
            if (rx_take) transport_layer_data_out <= rx_descr;
        end
    end

    assign st = '{sbrx: sbrx, cl0: cl0_s, state: state};

    always_comb begin
        rdata = '0;
        case (cfg.c_address)
            ADDR_ID:     rdata = DEV_ID;
            ADDR_CTRL:   rdata = {31'b0, sw_disable};
            ADDR_STATUS: rdata = 32'(st);
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            sw_disable     <= 1'b0;
            cfg.c_data_out <= '0;
        end else begin
            if (cfg.c_read) cfg.c_data_out <= rdata;
            if (cfg.c_write && cfg.c_address == ADDR_CTRL) sw_disable <= cfg.c_data_in[0];
        end
    end
endmodule

// File: tb/tb_usb4_lane_link_ctrl.sv
// Scenario bench for usb4_lane_link_ctrl: bring-up, training, loopback data, config space.
module tb_usb4_lane_link_ctrl;
    logic        local_clk = 1'b0;
    logic        rst, lane_disable, enable_deser, sbrx, loopback;
    logic [15:0] data_in, data_out;
    logic        flag, sbtx, enable_scr, cl0_s;
    logic [7:0]  tx0, tx1, rx0_drv, rx1_drv, rx0, rx1;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_data_q[$];
    logic [15:0] exp_tx_q[$];
    logic [22:0] m_lfsr;

    usb4_lane_link_ctrl_if cfg();

    assign rx0 = loopback ? tx0 : rx0_drv;
    assign rx1 = loopback ? tx1 : rx1_drv;

    always #5 local_clk = ~local_clk;

    usb4_lane_link_ctrl dut (
        .local_clk(local_clk), .rst(rst), .lane_disable(lane_disable), .cfg(cfg),
        .transport_layer_data_in(data_in), .transport_layer_data_out(data_out),
        .transport_data_flag(flag), .lane_0_rx_i(rx0), .lane_1_rx_i(rx1),
        .enable_deser(enable_deser), .sbrx(sbrx), .sbtx(sbtx),
        .lane_0_tx_o(tx0), .lane_1_tx_o(tx1), .enable_scr(enable_scr), .cl0_s(cl0_s)
    );

    // Reference keystream: returns {next_state, keystream_byte}.
    function automatic logic [30:0] m_ks(input logic [22:0] s);
        logic [7:0] k;
        for (int b = 0; b < 8; b++) begin
            k[b] = s[22];
            s = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
        end
        return {s, k};
    endfunction

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        cfg.c_read = 1'b1; cfg.c_address = a;
        tick();
        cfg.c_read = 1'b0;
        d = cfg.c_data_out;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg.c_write = 1'b1; cfg.c_address = a; cfg.c_data_in = d;
        tick();
        cfg.c_write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; lane_disable = 1'b1; sbrx = 1'b0; enable_deser = 1'b0; loopback = 1'b0;
        data_in = '0; rx0_drv = '0; rx1_drv = '0;
        cfg.c_read = 1'b0; cfg.c_write = 1'b0; cfg.c_address = '0; cfg.c_data_in = '0;
        tick(); tick();
        checks++; if ({sbtx, cl0_s, enable_scr, flag} !== 4'b0) begin
            errors++; $display("FAIL reset_ctl: got %b expected 0000", {sbtx, cl0_s, enable_scr, flag});
        end
        checks++; if ({tx1, tx0, data_out} !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {tx1, tx0, data_out});
        end
        checks++; if (cfg.c_data_out !== 32'h0) begin
            errors++; $display("FAIL reset_cdata: got %h expected 0", cfg.c_data_out);
        end
        rst = 1'b0;
        tick(); tick();
        checks++; if ({sbtx, cl0_s} !== 2'b00) begin
            errors++; $display("FAIL disabled_out: got %b expected 00", {sbtx, cl0_s});
        end
        cfg_read(8'h08, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL disabled_status: got %h expected 0", d);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        lane_disable = 1'b0;
        tick();
        checks++; if ({sbtx, cl0_s} !== 2'b10) begin
            errors++; $display("FAIL cld_out: got %b expected 10", {sbtx, cl0_s});
        end
        sbrx = 1'b1;
        repeat (7) tick();
        sbrx = 1'b0;
        tick();
        sbrx = 1'b1;
        repeat (7) tick();
        cfg_read(8'h08, d);  // 8th uninterrupted high cycle; read sees state before it
        checks++; if (d !== 32'h9) begin
            errors++; $display("FAIL debounce_cld: got %h expected 9", d);
        end
        cfg_read(8'h08, d);
        checks++; if (d !== 32'hA) begin
            errors++; $display("FAIL debounce_training: got %h expected a", d);
        end
        checks++; if ({tx1, tx0} !== 16'h4A4A) begin
            errors++; $display("FAIL training_ts: got %h expected 4a4a", {tx1, tx0});
        end
    endtask

    task automatic test_training();
        rx0_drv = 8'h4A;
        enable_deser = 1'b1;
        for (int w = 1; w <= 26; w++) begin
            rx1_drv = (w == 10) ? 8'h00 : 8'h4A;
            tick();
            if (w == 16 || w == 25) begin
                checks++; if (cl0_s !== 1'b0) begin
                    errors++; $display("FAIL early_cl0 word %0d: got %b expected 0", w, cl0_s);
                end
            end
        end
        enable_deser = 1'b0;
        checks++; if (cl0_s !== 1'b0) begin
            errors++; $display("FAIL cl0_lag: got %b expected 0", cl0_s);
        end
        tick();
        checks++; if ({cl0_s, enable_scr} !== 2'b11) begin
            errors++; $display("FAIL cl0_entry: got %b expected 11", {cl0_s, enable_scr});
        end
    endtask

    task automatic test_loopback();
        logic [15:0] pat [5];
        logic [15:0] exp, d;
        logic [7:0]  ks;
        int          nflag;
        pat = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h5A5A};
        m_lfsr = 23'h1DBFBC;
        nflag = 0;
        loopback = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            d = (k < 5) ? pat[k] : 16'h0000;
            data_in = d;
            enable_deser = (k > 0);
            {m_lfsr, ks} = m_ks(m_lfsr);
            exp_tx_q.push_back(d ^ {ks, ks});
            if (k < 5) exp_data_q.push_back(d);
            tick();
            exp = exp_tx_q.pop_front();
            checks++; if ({tx1, tx0} !== exp) begin
                errors++; $display("FAIL tx_scr k=%0d: got %h expected %h", k, {tx1, tx0}, exp);
            end
            if (k == 0) begin
                checks++; if (tx0 === 8'h34) begin
                    errors++; $display("FAIL tx_plain_leak: got %h expected not 34", tx0);
                end
            end
            if (flag === 1'b1) begin
                nflag++;
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++; $display("FAIL rx_extra: got %h expected none", data_out);
                end else begin
                    exp = exp_data_q.pop_front();
                    if (data_out !== exp) begin
                        errors++; $display("FAIL rx_data k=%0d: got %h expected %h", k, data_out, exp);
                    end
                end
            end
        end
        enable_deser = 1'b0;
        loopback = 1'b0;
        tick();
        checks++; if ({flag, data_out} !== {1'b0, 16'h5A5A}) begin
            errors++; $display("FAIL rx_hold: got %b/%h expected 0/5a5a", flag, data_out);
        end
        checks++; if (nflag != 5 || exp_data_q.size() != 0) begin
            errors++; $display("FAIL rx_count: got %0d flags, %0d left expected 5, 0", nflag, exp_data_q.size());
        end
    endtask

    task automatic test_retrain();
        logic [31:0] d;
        cfg_write(8'h04, 32'h2);
        checks++; if ({cl0_s, enable_scr} !== 2'b00) begin
            errors++; $display("FAIL retrain_cl0: got %b expected 00", {cl0_s, enable_scr});
        end
        cfg_read(8'h04, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL retrain_ctrl: got %h expected 0", d);
        end
        cfg_read(8'h08, d);
        checks++; if (d !== 32'hA) begin
            errors++; $display("FAIL retrain_status: got %h expected a", d);
        end
    endtask

    task automatic test_config();
        logic [31:0] d;
        cfg_write(8'h00, 32'h0);
        cfg_read(8'h00, d);
        checks++; if (d !== 32'h5553_4234) begin
            errors++; $display("FAIL id: got %h expected 55534234", d);
        end
        tick(); tick();
        checks++; if (cfg.c_data_out !== 32'h5553_4234) begin
            errors++; $display("FAIL rdata_hold: got %h expected 55534234", cfg.c_data_out);
        end
        cfg_read(8'h0C, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL unmapped: got %h expected 0", d);
        end
        cfg_write(8'h04, 32'h1);
        tick();
        checks++; if ({sbtx, cl0_s} !== 2'b00) begin
            errors++; $display("FAIL sw_disable: got %b expected 00", {sbtx, cl0_s});
        end
        cfg_read(8'h08, d);
        checks++; if (d !== 32'h8) begin
            errors++; $display("FAIL sw_dis_status: got %h expected 8", d);
        end
        cfg.c_read = 1'b1; cfg.c_write = 1'b1; cfg.c_address = 8'h04; cfg.c_data_in = 32'h0;
        tick();
        cfg.c_read = 1'b0; cfg.c_write = 1'b0;
        checks++; if (cfg.c_data_out !== 32'h1) begin
            errors++; $display("FAIL rw_same: got %h expected 1", cfg.c_data_out);
        end
        cfg_read(8'h04, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL ctrl_cleared: got %h expected 0", d);
        end
        checks++; if (sbtx !== 1'b1) begin
            errors++; $display("FAIL reenable_cld: got %b expected 1", sbtx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_training();
        test_loopback();
        test_retrain();
        test_config();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
